// File: rtl/rxpy_byte_buf_if.sv
// Decoder-side bit stream and link-controller FIFO read port of rxpy_byte_buf.
// The master drives the decoder strobes and rd_en; the slave (the buffer) returns FIFO and status.
interface rxpy_byte_buf_if #(
    parameter int AW = 5
) ();
    logic          dec_st_p;
    logic          bit_vld_p;
    logic          bit_in;
    logic          dec_endp;
    logic          crcgood;
    logic          existpyheader;
    logic          BRss;
    logic [12:0]   pylenbit;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          rx_done_p;
    logic          rx_crcok;
    logic [9:0]    rx_bytecnt;
    logic          rx_ovf;

    modport master (
        output dec_st_p, bit_vld_p, bit_in, dec_endp, crcgood,
        output existpyheader, BRss, pylenbit, rd_en,
        input  rd_data, fifo_empty, fifo_full, fifo_count,
        input  rx_done_p, rx_crcok, rx_bytecnt, rx_ovf
    );

    modport slave (
        input  dec_st_p, bit_vld_p, bit_in, dec_endp, crcgood,
        input  existpyheader, BRss, pylenbit, rd_en,
        output rd_data, fifo_empty, fifo_full, fifo_count,
        output rx_done_p, rx_crcok, rx_bytecnt, rx_ovf
    );
endinterface

// File: rtl/rxpy_byte_buf.sv
// Rx payload byte assembler: strips header, packs bits LSB-first into a FWFT byte FIFO.
// Define RXPYBUF_HDR_KEEP_EN to pack and store the header bytes ahead of the data.
module rxpy_byte_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input logic clk_6M,
    input logic rstz,
    rxpy_byte_buf_if.slave bus
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, TAIL, DONE} st_t;

    localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);

    st_t         st;
    logic [7:0]  sr;
    logic [3:0]  bcnt;
    logic [4:0]  hcnt;
    logic [12:0] dcnt;
    logic [12:0] plen;
    logic        hdr8;
    logic        wr_pend;
    logic [7:0]  wr_byte;
    logic        done_q;
    logic        crcok_q;
    logic [9:0]  bytecnt;
    logic        ovf_q;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;

    logic       take;
    logic       pack;
    logic [7:0] nsr;
    logic [3:0] nbc;
    logic       hdr_last;
    logic       dat_last;
    logic       endp;
    logic       flush;
    logic       full;
    logic       rd_do;
    logic       wr_do;

    always_comb begin
        take = bus.bit_vld_p && (st == HDR || st == DATA);
`ifdef RXPYBUF_HDR_KEEP_EN
        pack = take;
`else
        pack = bus.bit_vld_p && (st == DATA);
`endif
        nsr = sr;
        nbc = bcnt;
        // bit k of a byte lands at sr[k]: partial bytes come out zero-padded
        if (pack) begin
            nsr[bcnt[2:0]] = bus.bit_in;
            nbc = bcnt + 4'd1;
        end
        hdr_last = take && (st == HDR) && (hcnt == (hdr8 ? 5'd7 : 5'd15));
        dat_last = take && (st == DATA) && ((dcnt + 13'd1) == plen);
        endp     = bus.dec_endp && (st == HDR || st == DATA || st == TAIL);
        flush    = (nbc == 4'd8) || ((dat_last || endp) && (nbc != 4'd0));
    end

    assign full  = (cnt == FULLV);
    assign rd_do = bus.rd_en && (cnt != '0);
    assign wr_do = wr_pend && (!full || rd_do);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            st      <= IDLE;
            sr      <= '0;
            bcnt    <= '0;
            hcnt    <= '0;
            dcnt    <= '0;
            plen    <= '0;
            hdr8    <= 1'b0;
            wr_pend <= 1'b0;
            wr_byte <= '0;
            done_q  <= 1'b0;
            crcok_q <= 1'b0;
            bytecnt <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_pend <= 1'b0;
            if (bus.dec_st_p) begin
                sr      <= '0;
                bcnt    <= '0;
                hcnt    <= '0;
                dcnt    <= '0;
                plen    <= bus.pylenbit;
                hdr8    <= bus.BRss;
                bytecnt <= '0;
                if (bus.existpyheader)
                    st <= HDR;
                else if (bus.pylenbit == '0)
                    st <= TAIL;
                else
                    st <= DATA;
            end else begin
                sr   <= nsr;
                bcnt <= nbc;
                if (take && st == HDR)
                    hcnt <= hcnt + 5'd1;
                if (take && st == DATA)
                    dcnt <= dcnt + 13'd1;
                if (flush) begin
                    wr_pend <= 1'b1;
                    wr_byte <= nsr;
                    sr      <= '0;
                    bcnt    <= '0;
                    if (bytecnt != 10'd1023)
                        bytecnt <= bytecnt + 10'd1;
                end
                unique case (st)
                    IDLE: st <= IDLE;
                    HDR:  if (hdr_last) st <= (plen == '0) ? TAIL : DATA;
                    DATA: if (dat_last) st <= TAIL;
                    TAIL: st <= TAIL;
                    DONE: st <= IDLE;
                    default: st <= IDLE;
                endcase
                // completion overrides any header/data transition in the same cycle
                if (endp) begin
                    st      <= DONE;
                    done_q  <= 1'b1;
                    crcok_q <= bus.crcgood;
                end
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (bus.dec_st_p) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_do)
                wptr <= wptr + AW'(1);
            if (rd_do)
                rptr <= rptr + AW'(1);
            if (wr_do && !rd_do)
                cnt <= cnt + (AW+1)'(1);
            else if (!wr_do && rd_do)
                cnt <= cnt - (AW+1)'(1);
            if (wr_pend && !wr_do)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_do && !bus.dec_st_p) begin
            mem[wptr] <= wr_byte;
        end
    end

    assign bus.rd_data    = mem[rptr];
    assign bus.fifo_empty = (cnt == '0);
    assign bus.fifo_full  = full;
    assign bus.fifo_count = cnt;
    assign bus.rx_done_p  = done_q;
    assign bus.rx_crcok   = crcok_q;
    assign bus.rx_bytecnt = bytecnt;
    assign bus.rx_ovf     = ovf_q;

endmodule

// File: tb/tb_rxpy_byte_buf.sv
// Directed bench for rxpy_byte_buf: header strip, packing, FIFO full/overflow, abort,
// early end with partial byte, and asynchronous reset.
module tb_rxpy_byte_buf;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    int   nvec   = 0;
    int   errs   = 0;

    always #5 clk_6M = ~clk_6M;

    rxpy_byte_buf_if #(.AW(5)) b ();

    rxpy_byte_buf #(.DEPTH(32), .AW(5)) dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic start(input logic hdr, input logic brss, input logic [12:0] len);
        b.dec_st_p      = 1'b1;
        b.existpyheader = hdr;
        b.BRss          = brss;
        b.pylenbit      = len;
        cyc();
        b.dec_st_p = 1'b0;
    endtask

    task automatic sbits(input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            b.bit_vld_p = 1'b1;
            b.bit_in    = val[i];
            cyc();
        end
        b.bit_vld_p = 1'b0;
        b.bit_in    = 1'b0;
    endtask

    task automatic endp(input logic crc);
        b.dec_endp = 1'b1;
        b.crcgood  = crc;
        cyc();
        b.dec_endp = 1'b0;
        b.crcgood  = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        chk(tag, 32'(b.rd_data), 32'(exp));
        b.rd_en = 1'b1;
        cyc();
        b.rd_en = 1'b0;
    endtask

    initial begin
        b.dec_st_p      = 1'b0;
        b.bit_vld_p     = 1'b0;
        b.bit_in        = 1'b0;
        b.dec_endp      = 1'b0;
        b.crcgood       = 1'b0;
        b.existpyheader = 1'b0;
        b.BRss          = 1'b0;
        b.pylenbit      = '0;
        b.rd_en         = 1'b0;
        repeat (3) cyc();

        chk("rst_empty", 32'(b.fifo_empty), 32'd1);
        chk("rst_full", 32'(b.fifo_full), 32'd0);
        chk("rst_count", 32'(b.fifo_count), 32'd0);
        chk("rst_done", 32'(b.rx_done_p), 32'd0);
        chk("rst_bytecnt", 32'(b.rx_bytecnt), 32'd0);
        chk("rst_rd_data", 32'(b.rd_data), 32'd0);
        rstz = 1'b1;
        cyc();

        // 1: no header, A5 3C
        start(1'b0, 1'b0, 13'd16);
        sbits(32'hA5, 8);
        chk("t1_lat_empty", 32'(b.fifo_empty), 32'd1);
        cyc();
        chk("t1_lat_fill", 32'(b.fifo_empty), 32'd0);
        sbits(32'h3C, 8);
        sbits(32'h9, 4);
        endp(1'b1);
        chk("t1_done", 32'(b.rx_done_p), 32'd1);
        chk("t1_crcok", 32'(b.rx_crcok), 32'd1);
        chk("t1_bytecnt", 32'(b.rx_bytecnt), 32'd2);
        cyc();
        chk("t1_done_off", 32'(b.rx_done_p), 32'd0);
        chk("t1_count", 32'(b.fifo_count), 32'd2);
        pop("t1_b0", 8'hA5);
        pop("t1_b1", 8'h3C);
        chk("t1_empty", 32'(b.fifo_empty), 32'd1);

        // 2: 8-bit header 2A, 12 data bits 5F3, CRC bad
        start(1'b1, 1'b1, 13'd12);
        sbits(32'h2A, 8);
        sbits(32'h5F3, 12);
        sbits(32'h3, 4);
        endp(1'b0);
        chk("t2_done", 32'(b.rx_done_p), 32'd1);
        chk("t2_crcok", 32'(b.rx_crcok), 32'd0);
`ifdef RXPYBUF_HDR_KEEP_EN
        chk("t2_bytecnt", 32'(b.rx_bytecnt), 32'd3);
        cyc();
        pop("t2_h0", 8'h2A);
`else
        chk("t2_bytecnt", 32'(b.rx_bytecnt), 32'd2);
        cyc();
`endif
        pop("t2_b0", 8'hF3);
        pop("t2_b1", 8'h05);
        chk("t2_empty", 32'(b.fifo_empty), 32'd1);

        // 3: 40 bytes into 32-deep FIFO, one pop coincident with a write while full
        start(1'b0, 1'b0, 13'd320);
        for (int k = 0; k < 32; k++)
            sbits(32'(k), 8);
        cyc();
        chk("t3_count_full", 32'(b.fifo_count), 32'd32);
        chk("t3_full", 32'(b.fifo_full), 32'd1);
        chk("t3_ovf_pre", 32'(b.rx_ovf), 32'd0);
        sbits(32'd32, 8);
        b.rd_en = 1'b1;
        cyc();
        b.rd_en = 1'b0;
        chk("t3_rdwr_count", 32'(b.fifo_count), 32'd32);
        chk("t3_rdwr_ovf", 32'(b.rx_ovf), 32'd0);
        for (int k = 33; k < 40; k++)
            sbits(32'(k), 8);
        cyc();
        chk("t3_ovf", 32'(b.rx_ovf), 32'd1);
        chk("t3_count", 32'(b.fifo_count), 32'd32);
        chk("t3_bytecnt", 32'(b.rx_bytecnt), 32'd40);
        sbits(32'hFFFF, 16);
        endp(1'b1);
        chk("t3_done", 32'(b.rx_done_p), 32'd1);
        cyc();
        for (int k = 0; k < 32; k++)
            pop($sformatf("t3_pop%0d", k), 8'(k + 1));
        chk("t3_empty", 32'(b.fifo_empty), 32'd1);
        chk("t3_ovf_sticky", 32'(b.rx_ovf), 32'd1);

        // 4: abort mid-data after three bytes
        start(1'b0, 1'b0, 13'd64);
        sbits(32'h11, 8);
        sbits(32'h22, 8);
        sbits(32'h33, 8);
        cyc();
        chk("t4_count3", 32'(b.fifo_count), 32'd3);
        start(1'b0, 1'b0, 13'd8);
        chk("t4_abort_count", 32'(b.fifo_count), 32'd0);
        chk("t4_abort_ovf", 32'(b.rx_ovf), 32'd0);
        chk("t4_abort_bytecnt", 32'(b.rx_bytecnt), 32'd0);
        chk("t4_abort_done", 32'(b.rx_done_p), 32'd0);
        sbits(32'h77, 8);
        chk("t4_nodone", 32'(b.rx_done_p), 32'd0);
        endp(1'b1);
        chk("t4_done", 32'(b.rx_done_p), 32'd1);
        chk("t4_bytecnt", 32'(b.rx_bytecnt), 32'd1);
        cyc();
        pop("t4_b0", 8'h77);
        chk("t4_empty", 32'(b.fifo_empty), 32'd1);

        // 5: end after 10 of 16 bits, last bit coincident with dec_endp
        start(1'b0, 1'b0, 13'd16);
        sbits(32'h9C, 8);
        sbits(32'h0, 1);
        b.bit_vld_p = 1'b1;
        b.bit_in    = 1'b1;
        b.dec_endp  = 1'b1;
        b.crcgood   = 1'b1;
        cyc();
        b.bit_vld_p = 1'b0;
        b.bit_in    = 1'b0;
        b.dec_endp  = 1'b0;
        b.crcgood   = 1'b0;
        chk("t5_done", 32'(b.rx_done_p), 32'd1);
        chk("t5_bytecnt", 32'(b.rx_bytecnt), 32'd2);
        cyc();
        chk("t5_done_off", 32'(b.rx_done_p), 32'd0);
        pop("t5_b0", 8'h9C);
        pop("t5_b1", 8'h02);

        // 6: asynchronous reset mid-data
        start(1'b0, 1'b0, 13'd32);
        sbits(32'hFF, 8);
        cyc();
        chk("t6_pre_count", 32'(b.fifo_count), 32'd1);
        sbits(32'h3, 3);
        #2;
        rstz = 1'b0;
        #1;
        chk("t6_empty", 32'(b.fifo_empty), 32'd1);
        chk("t6_count", 32'(b.fifo_count), 32'd0);
        chk("t6_crcok", 32'(b.rx_crcok), 32'd0);
        chk("t6_bytecnt", 32'(b.rx_bytecnt), 32'd0);
        chk("t6_rd_data", 32'(b.rd_data), 32'd0);
        chk("t6_done", 32'(b.rx_done_p), 32'd0);
        chk("t6_ovf", 32'(b.rx_ovf), 32'd0);
        cyc();
        rstz = 1'b1;
        cyc();
        chk("t6_post_empty", 32'(b.fifo_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
